// File: rtl/core2axi4l_pipe.sv
// -----------------------------------------------------------------------------
// core2axi4l_pipe
//
// Bridges a simple req/gnt core bus onto an AXI4-Lite master port. Several
// transactions may be in flight, up to MaxOutstanding. All of them must be of
// the same type (all reads or all writes), so that responses from the B and R
// channels come back in issue order without any reordering storage.
//
// Optional feature (macro CORE2AXI4L_ERR_EN):
//   defined   : core_err = core_rvalid & resp[1] of the channel being answered
//   undefined : core_err = 0 and m_bresp / m_rresp are ignored
//
// Parameters
//   AddrWidth      : core / AXI address width
//   DataWidth      : data width (32 or 64); byte-enable width is DataWidth/8
//   MaxOutstanding : accepted-but-unanswered transaction limit (1..15)
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   core_req/gnt/we/addr/be/wdata : core request side
//   core_rvalid/rdata/err         : core response side (one per accepted req)
//   m_aw*, m_w*, m_b*             : AXI4-Lite write channels
//   m_ar*, m_r*                   : AXI4-Lite read channels
// -----------------------------------------------------------------------------
module core2axi4l_pipe #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   core_req,
  output logic                   core_gnt,
  input  logic                   core_we,
  input  logic [AddrWidth-1:0]   core_addr,
  input  logic [DataWidth/8-1:0] core_be,
  input  logic [DataWidth-1:0]   core_wdata,
  output logic                   core_rvalid,
  output logic [DataWidth-1:0]   core_rdata,
  output logic                   core_err,

  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [AddrWidth-1:0]   m_awaddr,
  output logic [2:0]             m_awprot,

  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic [DataWidth-1:0]   m_wdata,
  output logic [DataWidth/8-1:0] m_wstrb,

  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,

  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [AddrWidth-1:0]   m_araddr,
  output logic [2:0]             m_arprot,

  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DataWidth-1:0]   m_rdata,
  input  logic [1:0]             m_rresp
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] cnt;
  logic                cur_we;
  logic                aw_done;
  logic                w_done;

  logic slot_free;
  logic type_ok;
  logic issuable;
  logic issue_wr;
  logic issue_rd;
  logic aw_hs;
  logic w_hs;
  logic resp_take;

  // A request may go out only while there is room and it matches the type of
  // whatever is still in flight. The core holds its request until granted and
  // cnt can only fall without a grant, so once a valid has risen the request
  // stays issuable until its handshake completes. Reset forces everything low.
  assign slot_free = (cnt < CntMax);
  assign type_ok   = (cnt == '0) || (core_we == cur_we);
  assign issuable  = !rst && core_req && slot_free && type_ok;
  assign issue_wr  = issuable && core_we;
  assign issue_rd  = issuable && !core_we;

  assign m_awvalid = issue_wr && !aw_done;
  assign m_wvalid  = issue_wr && !w_done;
  assign m_arvalid = issue_rd;

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  // A write is accepted when both of its channels have handshaken, either in
  // an earlier cycle (sticky flag) or right now.
  assign core_gnt = (issue_rd && m_arready)
                  || (issue_wr && (aw_done || aw_hs) && (w_done || w_hs));

  assign m_awaddr = core_addr;
  assign m_araddr = core_addr;
  assign m_wdata  = core_wdata;
  assign m_wstrb  = core_be;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_bready = 1'b1;
  assign m_rready = 1'b1;

  // Responses with nothing outstanding are strays and are dropped. All
  // in-flight transactions share cur_we, so it tells which channel answers.
  assign resp_take   = (m_bvalid || m_rvalid) && (cnt != '0);
  assign core_rvalid = resp_take;
  assign core_rdata  = (resp_take && !cur_we) ? m_rdata : '0;

`ifdef CORE2AXI4L_ERR_EN
  assign core_err = resp_take && (cur_we ? m_bresp[1] : m_rresp[1]);
  logic unused_resp;
  assign unused_resp = m_bresp[0] ^ m_rresp[0];
`else
  assign core_err = 1'b0;
  logic unused_resp;
  assign unused_resp = ^{m_bresp, m_rresp};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cur_we  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (core_gnt) begin
        cur_we  <= core_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      // Grant and response in the same cycle cancel out.
      case ({core_gnt, resp_take})
        2'b10:   cnt <= cnt + CntOne;
        2'b01:   cnt <= cnt - CntOne;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_core2axi4l_pipe.sv
module tb_core2axi4l_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

`ifdef CORE2AXI4L_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_gnt, core_we;
  logic [AW-1:0] core_addr;
  logic [DW/8-1:0] core_be;
  logic [DW-1:0] core_wdata;
  logic          core_rvalid, core_err;
  logic [DW-1:0] core_rdata;
  logic          m_awvalid, m_awready;
  logic [AW-1:0] m_awaddr;
  logic [2:0]    m_awprot;
  logic          m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_bvalid, m_bready;
  logic [1:0]    m_bresp;
  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arprot;
  logic          m_rvalid, m_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;

  int checks = 0;
  int errors = 0;

  core2axi4l_pipe #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
    .core_addr(core_addr), .core_be(core_be), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_be = '0; core_wdata = '0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 2'b00; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic drive_req(input bit we, input logic [AW-1:0] addr,
                           input logic [DW/8-1:0] be, input logic [DW-1:0] wdata);
    core_req = 1; core_we = we; core_addr = addr; core_be = be; core_wdata = wdata;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    drive_req(0, 32'h0000_0040, 4'hF, '0);
    m_arready = 1; m_rvalid = 1; m_bvalid = 1; m_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      #4;
      checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b want 0", m_arvalid); end
      checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_awwvalid: got %b%b want 00", m_awvalid, m_wvalid); end
      checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", core_gnt); end
      checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", core_rvalid); end
      checks++; if (core_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", core_err); end
      checks++; if (m_bready !== 1'b1 || m_rready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b%b want 11", m_bready, m_rready); end
      checks++; if (m_awprot !== 3'b000 || m_arprot !== 3'b000) begin errors++; $display("FAIL prot: got %b %b want 000", m_awprot, m_arprot); end
      @(posedge clk);
    end
    #1;
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_read_basic();
    step();
    drive_req(0, 32'h0000_1000, 4'hF, '0); m_arready = 1;
    #3;
    checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid: got %b want 1", m_arvalid); end
    checks++; if (m_araddr !== 32'h1000) begin errors++; $display("FAIL rd_araddr: got %h want 00001000", m_araddr); end
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt0: got %b want 1", core_gnt); end
    step();
    clear_inputs();
    #3;
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b want 0", core_rvalid); end
    step();
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
    #3;
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", core_rvalid); end
    checks++; if (core_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", core_rdata); end
    checks++; if (core_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", core_err); end
    // A write is issued at once only if nothing is outstanding any more.
    step();
    clear_inputs();
    drive_req(1, 32'h0000_1004, 4'h3, 32'h0BAD_F00D); m_awready = 1; m_wready = 1;
    #3;
    checks++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin errors++; $display("FAIL rd_cnt_zero: got aw%b w%b want 11", m_awvalid, m_wvalid); end
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL wr_simul_gnt: got %b want 1", core_gnt); end
    step();
    clear_inputs(); m_bvalid = 1; m_rdata = 32'h1111_2222;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp: got v%b d%h want v1 d0", core_rvalid, core_rdata); end
    step();
    clear_inputs();
  endtask

  task automatic test_write_split();
    step();
    drive_req(1, 32'h0000_2000, 4'hF, 32'h1234_5678); m_awready = 1;
    #3;
    checks++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin errors++; $display("FAIL ws_valids: got aw%b w%b want 11", m_awvalid, m_wvalid); end
    checks++; if (m_awaddr !== 32'h2000 || m_wdata !== 32'h1234_5678 || m_wstrb !== 4'hF) begin errors++; $display("FAIL ws_payload: got %h %h %h want 00002000 12345678 f", m_awaddr, m_wdata, m_wstrb); end
    checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL ws_gnt_aw: got %b want 0", core_gnt); end
    for (int i = 0; i < 2; i++) begin
      step();
      m_awready = 0;
      #3;
      checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin errors++; $display("FAIL ws_wait%0d: got aw%b w%b want 01", i, m_awvalid, m_wvalid); end
      checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL ws_gnt_wait%0d: got %b want 0", i, core_gnt); end
    end
    step();
    m_wready = 1;
    #3;
    checks++; if (core_gnt !== 1'b1 || m_wstrb !== 4'hF) begin errors++; $display("FAIL ws_gnt_w: got g%b s%h want g1 sf", core_gnt, m_wstrb); end
    // W first, then AW.
    step();
    drive_req(1, 32'h0000_2004, 4'h5, 32'hCAFE_0001); m_awready = 0; m_wready = 1;
    #3;
    checks++; if (core_gnt !== 1'b0 || m_wstrb !== 4'h5) begin errors++; $display("FAIL ws2_gnt_w: got g%b s%h want g0 s5", core_gnt, m_wstrb); end
    step();
    m_wready = 0; m_awready = 1; m_bvalid = 1;
    #3;
    checks++; if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || core_gnt !== 1'b1) begin errors++; $display("FAIL ws2_gnt_aw: got w%b aw%b g%b want 011", m_wvalid, m_awvalid, core_gnt); end
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL ws_resp1: got %b want 1", core_rvalid); end
    step();
    clear_inputs(); m_bvalid = 1;
    #3;
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL ws_resp2: got %b want 1", core_rvalid); end
    step();
    clear_inputs(); m_bvalid = 1;
    #3;
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL ws_stray: got %b want 0", core_rvalid); end
    step();
    clear_inputs();
  endtask

  task automatic test_max_outstanding();
    for (int i = 0; i < 2; i++) begin
      step();
      drive_req(0, 32'h0000_3000 + 32'(i * 4), 4'hF, '0); m_arready = 1;
      #3;
      checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL mo_gnt%0d: got %b want 1", i, core_gnt); end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      drive_req(0, 32'h0000_3008, 4'hF, '0);
      #3;
      checks++; if (core_gnt !== 1'b0 || m_arvalid !== 1'b0) begin errors++; $display("FAIL mo_full%0d: got g%b ar%b want 00", i, core_gnt, m_arvalid); end
    end
    step();
    m_rvalid = 1; m_rdata = 32'hA0A0_0001;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hA0A0_0001) begin errors++; $display("FAIL mo_resp1: got v%b d%h want v1 da0a00001", core_rvalid, core_rdata); end
    checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL mo_gnt_same: got %b want 0", core_gnt); end
    step();
    m_rvalid = 0;
    #3;
    checks++; if (core_gnt !== 1'b1 || m_araddr !== 32'h3008) begin errors++; $display("FAIL mo_gnt3: got g%b a%h want g1 a00003008", core_gnt, m_araddr); end
    for (int i = 0; i < 2; i++) begin
      step();
      clear_inputs(); m_rvalid = 1; m_rdata = 32'hB0B0_0000 + 32'(i);
      #3;
      checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hB0B0_0000 + 32'(i)) begin errors++; $display("FAIL mo_drain%0d: got v%b d%h", i, core_rvalid, core_rdata); end
    end
    step();
    clear_inputs(); m_rvalid = 1;
    #3;
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL mo_stray: got %b want 0", core_rvalid); end
    step();
    clear_inputs();
  endtask

  task automatic test_type_mismatch();
    step();
    drive_req(0, 32'h0000_4000, 4'hF, '0); m_arready = 1;
    #3;
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL tm_rd_gnt: got %b want 1", core_gnt); end
    for (int i = 0; i < 2; i++) begin
      step();
      drive_req(1, 32'h0000_4100, 4'hF, 32'h7777_0000); m_awready = 1; m_wready = 1; m_arready = 0;
      #3;
      checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || core_gnt !== 1'b0) begin errors++; $display("FAIL tm_hold%0d: got aw%b w%b g%b want 000", i, m_awvalid, m_wvalid, core_gnt); end
    end
    step();
    m_rvalid = 1; m_rdata = 32'h4444_0000;
    #3;
    checks++; if (core_rvalid !== 1'b1 || m_awvalid !== 1'b0) begin errors++; $display("FAIL tm_resp: got v%b aw%b want v1 aw0", core_rvalid, m_awvalid); end
    step();
    m_rvalid = 0;
    #3;
    checks++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || core_gnt !== 1'b1) begin errors++; $display("FAIL tm_issue: got aw%b w%b g%b want 111", m_awvalid, m_wvalid, core_gnt); end
    step();
    clear_inputs(); m_bvalid = 1;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h0) begin errors++; $display("FAIL tm_wresp: got v%b d%h want v1 d0", core_rvalid, core_rdata); end
    step();
    clear_inputs();
  endtask

  task automatic test_err();
    step();
    drive_req(1, 32'h0000_5000, 4'hF, 32'h5555_5555); m_awready = 1; m_wready = 1;
    #3;
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL err_wgnt: got %b want 1", core_gnt); end
    step();
    clear_inputs(); m_bvalid = 1; m_bresp = 2'b10; m_rresp = 2'b00;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_err !== ErrEn) begin errors++; $display("FAIL err_bresp: got v%b e%b want v1 e%b", core_rvalid, core_err, ErrEn); end
    step();
    clear_inputs();
    drive_req(0, 32'h0000_5004, 4'hF, '0); m_arready = 1;
    #3;
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL err_rgnt: got %b want 1", core_gnt); end
    step();
    clear_inputs(); m_rvalid = 1; m_rresp = 2'b11; m_bresp = 2'b00; m_rdata = 32'h0E0E_0E0E;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_err !== ErrEn || core_rdata !== 32'h0E0E_0E0E) begin errors++; $display("FAIL err_rresp: got v%b e%b d%h want e%b", core_rvalid, core_err, core_rdata, ErrEn); end
    step();
    clear_inputs(); m_rvalid = 1; m_rresp = 2'b10;
    #3;
    checks++; if (core_err !== 1'b0) begin errors++; $display("FAIL err_stray: got %b want 0", core_err); end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_inflight();
    step();
    drive_req(1, 32'h0000_6000, 4'hF, 32'hA5A5_A5A5); m_awready = 1; m_wready = 1;
    #3;
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL ri_gnt: got %b want 1", core_gnt); end
    step();
    drive_req(1, 32'h0000_6004, 4'hF, 32'h5A5A_5A5A); m_awready = 0; m_wready = 0;
    #3;
    checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL ri_awvalid: got %b want 1", m_awvalid); end
    #1;
    rst = 1; m_bvalid = 1; m_awready = 1;
    #1;
    checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_arvalid !== 1'b0) begin errors++; $display("FAIL ri_valids: got aw%b w%b ar%b want 000", m_awvalid, m_wvalid, m_arvalid); end
    checks++; if (core_gnt !== 1'b0 || core_rvalid !== 1'b0) begin errors++; $display("FAIL ri_gnt_rv: got g%b v%b want 00", core_gnt, core_rvalid); end
    step();
    step();
    clear_inputs(); rst = 0; m_rvalid = 1; m_bvalid = 1;
    #3;
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL ri_stray: got %b want 0", core_rvalid); end
    step();
    clear_inputs();
    drive_req(0, 32'h0000_6100, 4'hF, '0); m_arready = 1;
    #3;
    checks++; if (m_arvalid !== 1'b1 || core_gnt !== 1'b1) begin errors++; $display("FAIL ri_cleared: got ar%b g%b want 11", m_arvalid, core_gnt); end
    step();
    clear_inputs(); m_rvalid = 1; m_rdata = 32'h0000_0055;
    #3;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h55) begin errors++; $display("FAIL ri_resp: got v%b d%h want v1 d55", core_rvalid, core_rdata); end
    step();
    clear_inputs();
  endtask

  // Reference model: a queue of the types of accepted-but-unanswered
  // transactions, plus which write channels have already been accepted.
  task automatic test_random();
    bit q[$];
    bit have_req = 0, req_we = 0, aw_seen = 0, w_seen = 0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_wdata = '0;
    logic [DW/8-1:0] r_be = '0;
    bit issuable, e_aw, e_w, e_ar, e_gnt, e_rv, e_err;
    logic [DW-1:0] e_rdata;
    int n;
    clear_inputs();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (!have_req && $urandom_range(0, 2) == 0) begin
        have_req = 1; req_we = 1'($urandom_range(0, 1));
        r_addr = $urandom; r_wdata = $urandom; r_be = 4'($urandom);
      end
      core_req = have_req; core_we = req_we; core_addr = r_addr; core_be = r_be; core_wdata = r_wdata;
      m_awready = 1'($urandom_range(0, 1)); m_wready = 1'($urandom_range(0, 1)); m_arready = 1'($urandom_range(0, 1));
      m_bvalid = 0; m_rvalid = 0; m_rdata = $urandom; m_bresp = 2'($urandom); m_rresp = 2'($urandom);
      n = q.size();
      if (n > 0 && $urandom_range(0, 2) == 0) begin
        if (q[0]) m_bvalid = 1; else m_rvalid = 1;
      end else if (n == 0 && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) m_bvalid = 1; else m_rvalid = 1;
      end
      issuable = have_req && n < MO && (n == 0 || req_we == q[0]);
      e_aw  = issuable && req_we && !aw_seen;
      e_w   = issuable && req_we && !w_seen;
      e_ar  = issuable && !req_we;
      e_gnt = issuable && (req_we ? ((aw_seen || m_awready) && (w_seen || m_wready)) : m_arready);
      e_rv  = (m_bvalid || m_rvalid) && n > 0;
      e_rdata = (e_rv && !q[0]) ? m_rdata : '0;
      e_err = ErrEn && e_rv && (q[0] ? m_bresp[1] : m_rresp[1]);
      #3;
      checks++; if (core_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, core_gnt, e_gnt); end
      checks++; if ({m_awvalid, m_wvalid, m_arvalid} !== {e_aw, e_w, e_ar}) begin errors++; $display("FAIL rnd_valids c%0d: got %b%b%b want %b%b%b", cyc, m_awvalid, m_wvalid, m_arvalid, e_aw, e_w, e_ar); end
      checks++; if (core_rvalid !== e_rv) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, core_rvalid, e_rv); end
      checks++; if (e_rv && core_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, core_rdata, e_rdata); end
      checks++; if (core_err !== e_err) begin errors++; $display("FAIL rnd_err c%0d: got %b want %b", cyc, core_err, e_err); end
      if (e_aw || e_w) begin
        checks++; if (m_awaddr !== r_addr || m_wdata !== r_wdata || m_wstrb !== r_be) begin errors++; $display("FAIL rnd_wpayload c%0d: got %h %h %h want %h %h %h", cyc, m_awaddr, m_wdata, m_wstrb, r_addr, r_wdata, r_be); end
      end
      if (e_ar) begin
        checks++; if (m_araddr !== r_addr) begin errors++; $display("FAIL rnd_araddr c%0d: got %h want %h", cyc, m_araddr, r_addr); end
      end
      if (e_rv) void'(q.pop_front());
      if (e_gnt) begin
        q.push_back(req_we); have_req = 0; aw_seen = 0; w_seen = 0;
      end else begin
        if (e_aw && m_awready) aw_seen = 1;
        if (e_w && m_wready) w_seen = 1;
      end
    end
    for (int i = 0; i < MO + 2 && q.size() > 0; i++) begin
      step();
      clear_inputs();
      if (q[0]) m_bvalid = 1; else m_rvalid = 1;
      #3;
      checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL rnd_drain%0d: got %b want 1", i, core_rvalid); end
      void'(q.pop_front());
    end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_split();
    test_max_outstanding();
    test_type_mismatch();
    test_err();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core2axi4l_pipe.md
CORE2AXI4L_PIPE -- requirements
Module: core2axi4l_pipe

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: width of core and AXI addresses.
REQ-002 SHALL have parameter DataWidth, default 32: data width, legal values 32 or 64; strobe/byte-enable width is DataWidth/8.
REQ-003 SHALL have parameter MaxOutstanding, default 2: maximum accepted-but-unanswered transactions, legal range 1..15.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 core_req  in  1  core request, held with stable attributes until core_gnt.
REQ-007 core_gnt  out  1  request accepted this cycle.
REQ-008 core_we  in  1  1 = write, 0 = read.
REQ-009 core_addr  in  AddrWidth  byte address.
REQ-010 core_be  in  DataWidth/8  byte enables.
REQ-011 core_wdata  in  DataWidth  write data.
REQ-012 core_rvalid  out  1  response valid, one cycle per accepted request.
REQ-013 core_rdata  out  DataWidth  read data; 0 for write responses.
REQ-014 core_err  out  1  response error, qualified by core_rvalid.
REQ-015 m_awvalid, m_awready  out/in  1 each  AXI4-Lite write-address handshake.
REQ-016 m_awaddr  out  AddrWidth  write address (= core_addr).
REQ-017 m_wvalid, m_wready  out/in  1 each  write-data handshake.
REQ-018 m_wdata  out  DataWidth; m_wstrb  out  DataWidth/8  (= core_wdata, core_be).
REQ-019 m_bvalid  in  1; m_bready  out  1, constant 1; m_bresp  in  2.
REQ-020 m_arvalid, m_arready  out/in  1 each  read-address handshake.
REQ-021 m_araddr  out  AddrWidth  read address (= core_addr).
REQ-022 m_rvalid  in  1; m_rready  out  1, constant 1; m_rdata  in  DataWidth; m_rresp  in  2.
REQ-023 m_awprot, m_arprot  out  3 each  constant 3'b000.

Function
REQ-024 Outstanding counter cnt (0..MaxOutstanding) and type flag cur_we SHALL be kept; a request is issuable iff core_req and cnt<MaxOutstanding and (cnt==0 or core_we==cur_we).
REQ-025 Issuable write: m_awvalid and m_wvalid asserted together; each deasserts after its own handshake (sticky done flags aw_done, w_done); core_gnt pulses in the cycle the later of the two handshakes completes (same cycle if simultaneous); flags clear on gnt.
REQ-026 Issuable read: m_arvalid asserted; core_gnt = m_arvalid & m_arready, combinational; best-case gnt latency 0 cycles.
REQ-027 Once m_awvalid/m_wvalid/m_arvalid rises it SHALL stay high until its handshake (AXI rule), independent of cnt.
REQ-028 On core_gnt: cnt+1, cur_we<=core_we; on m_bvalid or m_rvalid: cnt-1; both in one cycle: cnt unchanged.
REQ-029 core_rvalid = (m_bvalid | m_rvalid) & cnt!=0, same cycle; core_rdata = m_rdata on reads, 0 on writes; responses returned in issue order.
REQ-030 cnt==MaxOutstanding or type mismatch: no new valid raised, core_gnt=0, until cnt permits (registered cnt, earliest next cycle).
REQ-031 Response with cnt==0: ignored, core_rvalid=0, cnt stays 0.

Reset
REQ-032 rst SHALL clear cnt, cur_we, aw_done, w_done; during and after reset all m_*valid, core_gnt, core_rvalid, core_err = 0, m_bready = m_rready = 1; in-flight transactions are dropped.

Configuration
REQ-033 With CORE2AXI4L_ERR_EN defined, core_err = core_rvalid & (read ? m_rresp[1] : m_bresp[1]); without it core_err = 0 and resp inputs are unused.

Verification
REQ-034 Read 0x1000, m_arready=1, m_rvalid 2 cycles later with rdata 0xDEADBEEF -> gnt same cycle as req, core_rvalid with rdata 0xDEADBEEF, cnt back to 0.
REQ-035 Write 0x2000 data 0x12345678 be 0xF, m_wready 3 cycles after m_awready -> awvalid drops after AW handshake, gnt only on W handshake, m_wstrb=0xF.
REQ-036 MaxOutstanding=2, three back-to-back reads, no responses -> third request waits, gnt=0 until first m_rvalid, then granted.
REQ-037 Read outstanding then write request -> write held (no awvalid) until read response returns, cnt 0, then issued.
REQ-038 ERR_EN defined, m_bresp=2'b10 -> core_err=1 with core_rvalid; undefined -> core_err=0.
REQ-039 rst asserted with awvalid high and cnt=1 -> all valids 0 immediately, cnt=0; stray m_rvalid after reset -> no core_rvalid.
